// File: rtl/tlc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlc_pkg
// Description : Shared types and constants for the two-approach traffic light
//               controller: phase encoding, phase-to-lamp decode and the
//               normal-cycle successor function.
// Revision    : 1.0 - initial release
// ============================================================================
package tlc_pkg;

    // Phase encoding, also consumed by the display logic.
    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        CLR_1     = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        CLR_2     = 3'd5,
        FLASH     = 3'd6
    } phase_t;

    // Lamp vector layout: {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}
    localparam logic [5:0] c_lamps_ns_green  = 6'b001_100;
    localparam logic [5:0] c_lamps_ns_yellow = 6'b010_100;
    localparam logic [5:0] c_lamps_all_red   = 6'b100_100;
    localparam logic [5:0] c_lamps_ew_green  = 6'b100_001;
    localparam logic [5:0] c_lamps_ew_yellow = 6'b100_010;
    localparam logic [5:0] c_lamps_dark      = 6'b000_000;
    localparam logic [5:0] c_lamps_flash_on  = 6'b010_010;

    // Steady lamp pattern of a phase; FLASH yellow is overlaid by the caller.
    function automatic logic [5:0] phase_lamps(input phase_t p);
        case (p)
            NS_GREEN:  return c_lamps_ns_green;
            NS_YELLOW: return c_lamps_ns_yellow;
            CLR_1:     return c_lamps_all_red;
            EW_GREEN:  return c_lamps_ew_green;
            EW_YELLOW: return c_lamps_ew_yellow;
            CLR_2:     return c_lamps_all_red;
            default:   return c_lamps_dark;
        endcase
    endfunction

    // Successor in the normal cycle; FLASH always leaves through CLR_2.
    function automatic phase_t next_phase(input phase_t p);
        case (p)
            NS_GREEN:  return NS_YELLOW;
            NS_YELLOW: return CLR_1;
            CLR_1:     return EW_GREEN;
            EW_GREEN:  return EW_YELLOW;
            EW_YELLOW: return CLR_2;
            CLR_2:     return NS_GREEN;
            default:   return CLR_2;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlc_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : tlc_phase_timer
// Description : CW-bit loadable down-counter. Load wins over counting; the
//               counter decrements on tick and saturates at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module tlc_phase_timer #(
    parameter int          CW      = 6,
    parameter logic [CW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          tick,
    output logic [CW-1:0] count,
    output logic          zero
);

    localparam logic [CW-1:0] c_one = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] r_count;

    // Count register: reload, or step down on tick until zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= RST_VAL;
        end else if (load) begin
            r_count <= load_val;
        end else if (tick && (r_count != '0)) begin
            r_count <= r_count - c_one;
        end
    end

    assign count = r_count;
    assign zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_ctrl
// Description : Two-approach (NS/EW) intersection controller with all-red
//               clearance, per-phase countdown, night flashing-yellow mode and
//               an optional pedestrian green truncation.
//               Build option: define TLC_PED_EN to enable the pedestrian latch.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_ctrl
    import tlc_pkg::*;
#(
    parameter int CW        = 6,
    parameter int GREEN_T   = 30,
    parameter int YELLOW_T  = 3,
    parameter int RED_CLR_T = 2,
    parameter int PED_T     = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          night,
    input  logic          ped_req,
    output logic          ns_red,
    output logic          ns_yellow,
    output logic          ns_green,
    output logic          ew_red,
    output logic          ew_yellow,
    output logic          ew_green,
    output logic [CW-1:0] count,
    output logic [2:0]    phase
);

    localparam logic [CW-1:0] c_green_load  = CW'(GREEN_T - 1);
    localparam logic [CW-1:0] c_yellow_load = CW'(YELLOW_T - 1);
    localparam logic [CW-1:0] c_clr_load    = CW'(RED_CLR_T - 1);
    localparam logic [CW-1:0] c_ped_load    = CW'(PED_T - 1);

    phase_t        r_state;
    phase_t        w_next_state;
    logic          r_flash_on;
    logic          w_next_flash;
    logic [5:0]    r_lamps;
    logic          w_load;
    logic [CW-1:0] w_load_val;
    logic [CW-1:0] w_count;
    logic          w_zero;
    logic          w_ped_pending;
    logic          w_trunc;
    logic          w_yellow_entry;

    // Reload value for a phase being entered.
    function automatic logic [CW-1:0] entry_load(input phase_t p);
        case (p)
            NS_GREEN, EW_GREEN:   return c_green_load;
            NS_YELLOW, EW_YELLOW: return c_yellow_load;
            CLR_1, CLR_2:         return c_clr_load;
            default:              return '0;
        endcase
    endfunction

    tlc_phase_timer #(
        .CW      (CW),
        .RST_VAL (c_green_load)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .tick     (tick),
        .count    (w_count),
        .zero     (w_zero)
    );

`ifdef TLC_PED_EN
    logic r_ped_latch;

    // Sticky pedestrian request, consumed when either yellow begins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ped_latch <= 1'b0;
        end else if (w_yellow_entry) begin
            r_ped_latch <= 1'b0;
        end else if (ped_req) begin
            r_ped_latch <= 1'b1;
        end
    end

    // A press on the current cycle counts as already latched.
    assign w_ped_pending = r_ped_latch | ped_req;
`else
    logic w_unused_ped;
    assign w_unused_ped  = ped_req | c_ped_load[0];
    assign w_ped_pending = 1'b0;
`endif

    assign w_trunc = ((r_state == NS_GREEN) || (r_state == EW_GREEN))
                   && w_ped_pending && (w_count > c_ped_load);

    assign w_yellow_entry = (w_next_state != r_state)
                          && ((w_next_state == NS_YELLOW) || (w_next_state == EW_YELLOW));

    // Next state, timer reload and flash phase; nothing moves without tick.
    always_comb begin
        w_next_state = r_state;
        w_next_flash = r_flash_on;
        w_load       = 1'b0;
        w_load_val   = '0;
        if (tick) begin
            if (r_state == FLASH) begin
                if (!night) begin
                    w_next_state = CLR_2;
                    w_next_flash = 1'b0;
                    w_load       = 1'b1;
                    w_load_val   = c_clr_load;
                end else begin
                    w_next_flash = ~r_flash_on;
                end
            end else if (w_zero) begin
                // Night wins over any pending truncation at a boundary.
                if (night) begin
                    w_next_state = FLASH;
                    w_next_flash = 1'b1;
                    w_load       = 1'b1;
                    w_load_val   = '0;
                end else begin
                    w_next_state = next_phase(r_state);
                    w_load       = 1'b1;
                    w_load_val   = entry_load(next_phase(r_state));
                end
            end else if (w_trunc) begin
                w_load     = 1'b1;
                w_load_val = c_ped_load;
            end
        end
    end

    // State, flash phase and registered lamp drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= NS_GREEN;
            r_flash_on <= 1'b0;
            r_lamps    <= c_lamps_ns_green;
        end else begin
            r_state    <= w_next_state;
            r_flash_on <= w_next_flash;
            if (w_next_state == FLASH) begin
                r_lamps <= w_next_flash ? c_lamps_flash_on : c_lamps_dark;
            end else begin
                r_lamps <= phase_lamps(w_next_state);
            end
        end
    end

    assign {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} = r_lamps;
    assign count = w_count;
    assign phase = r_state;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_light_ctrl
// Description : Directed self-checking bench for traffic_light_ctrl with
//               GREEN_T=4, YELLOW_T=2, RED_CLR_T=1, PED_T=2.
//               Expectations follow TLC_PED_EN when the bench is built with it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_ctrl;

    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic          night = 1'b0;
    logic          ped_req = 1'b0;
    logic          ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
    logic [CW-1:0] count;
    logic [2:0]    phase;

    int n_checks = 0;
    int n_fail   = 0;

    traffic_light_ctrl #(
        .CW(CW), .GREEN_T(4), .YELLOW_T(2), .RED_CLR_T(1), .PED_T(2)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .night(night), .ped_req(ped_req),
        .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
        .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
        .count(count), .phase(phase)
    );

    always #5 clk = ~clk;

    // Hand-written lamp table {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g} per steady phase.
    function automatic logic [5:0] lamps_for(input logic [2:0] ph);
        case (ph)
            3'd0:    return 6'b001100;
            3'd1:    return 6'b010100;
            3'd2:    return 6'b100100;
            3'd3:    return 6'b100001;
            3'd4:    return 6'b100010;
            3'd5:    return 6'b100100;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic logic [5:0] lamps_now();
        return {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green};
    endfunction

    // One clock, then settle away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick = 1'b0; night = 1'b0; ped_req = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (phase !== 3'd0) begin n_fail++; $display("FAIL reset_phase got %0d want 0", phase); end
        n_checks++;
        if (count !== 6'd3) begin n_fail++; $display("FAIL reset_count got %0d want 3", count); end
        n_checks++;
        if (lamps_now() !== 6'b001100) begin n_fail++; $display("FAIL reset_lamps got %b want 001100", lamps_now()); end
    endtask

    task automatic test_full_cycle();
        logic [2:0] exp_ph [0:13];
        logic [5:0] exp_ct [0:13];
        exp_ph = '{3'd0,3'd0,3'd0,3'd1,3'd1,3'd2,3'd3,3'd3,3'd3,3'd3,3'd4,3'd4,3'd5,3'd0};
        exp_ct = '{6'd2,6'd1,6'd0,6'd1,6'd0,6'd0,6'd3,6'd2,6'd1,6'd0,6'd1,6'd0,6'd0,6'd3};
        do_reset();
        tick = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step();
            n_checks++;
            if (phase !== exp_ph[i] || count !== exp_ct[i]) begin
                n_fail++;
                $display("FAIL cycle_tick%0d got phase=%0d count=%0d want phase=%0d count=%0d",
                         i + 1, phase, count, exp_ph[i], exp_ct[i]);
            end
            n_checks++;
            if (lamps_now() !== lamps_for(exp_ph[i])) begin
                n_fail++;
                $display("FAIL cycle_lamps%0d got %b want %b", i + 1, lamps_now(), lamps_for(exp_ph[i]));
            end
        end
        tick = 1'b0;
    endtask

    task automatic test_tick_hold();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if (phase !== 3'd0 || count !== 6'd3 || lamps_now() !== 6'b001100) begin
                n_fail++;
                $display("FAIL hold_cycle%0d got phase=%0d count=%0d lamps=%b want 0/3/001100",
                         i, phase, count, lamps_now());
            end
        end
    endtask

    task automatic test_night();
        logic [5:0] exp_fl [0:2];
        exp_fl = '{6'b010010, 6'b000000, 6'b010010};
        do_reset();
        tick = 1'b1;
        repeat (4) step();
        n_checks++;
        if (phase !== 3'd1 || count !== 6'd1) begin
            n_fail++; $display("FAIL night_pre got phase=%0d count=%0d want 1/1", phase, count);
        end
        night = 1'b1;
        step();
        n_checks++;
        if (phase !== 3'd1 || count !== 6'd0) begin
            n_fail++; $display("FAIL night_yellow_end got phase=%0d count=%0d want 1/0", phase, count);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (phase !== 3'd6 || count !== 6'd0 || lamps_now() !== exp_fl[i]) begin
                n_fail++;
                $display("FAIL flash%0d got phase=%0d count=%0d lamps=%b want 6/0/%b",
                         i, phase, count, lamps_now(), exp_fl[i]);
            end
        end
        night = 1'b0;
        step();
        n_checks++;
        if (phase !== 3'd5 || count !== 6'd0 || lamps_now() !== 6'b100100) begin
            n_fail++;
            $display("FAIL night_exit_clr got phase=%0d count=%0d lamps=%b want 5/0/100100", phase, count, lamps_now());
        end
        step();
        n_checks++;
        if (phase !== 3'd0 || count !== 6'd3 || lamps_now() !== 6'b001100) begin
            n_fail++;
            $display("FAIL night_resume got phase=%0d count=%0d lamps=%b want 0/3/001100", phase, count, lamps_now());
        end
        tick = 1'b0;
    endtask

    task automatic test_ped();
        logic [2:0] exp_ph [0:9];
        logic [5:0] exp_ct [0:9];
`ifdef TLC_PED_EN
        exp_ph = '{3'd0,3'd0,3'd1,3'd1,3'd2,3'd3,3'd3,3'd3,3'd3,3'd4};
        exp_ct = '{6'd1,6'd0,6'd1,6'd0,6'd0,6'd3,6'd2,6'd1,6'd0,6'd1};
`else
        exp_ph = '{3'd0,3'd0,3'd0,3'd1,3'd1,3'd2,3'd3,3'd3,3'd3,3'd3};
        exp_ct = '{6'd2,6'd1,6'd0,6'd1,6'd0,6'd0,6'd3,6'd2,6'd1,6'd0};
`endif
        do_reset();
        tick = 1'b1;
        ped_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            ped_req = 1'b0;
            n_checks++;
            if (phase !== exp_ph[i] || count !== exp_ct[i]) begin
                n_fail++;
                $display("FAIL ped_tick%0d got phase=%0d count=%0d want phase=%0d count=%0d",
                         i + 1, phase, count, exp_ph[i], exp_ct[i]);
            end
        end
        tick = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick = 1'b1;
        repeat (11) step();
        n_checks++;
        if (phase !== 3'd4 || count !== 6'd1) begin
            n_fail++; $display("FAIL mid_pre got phase=%0d count=%0d want 4/1", phase, count);
        end
        rst = 1'b1;
        ped_req = 1'b1;
        night = 1'b1;
        step();
        n_checks++;
        if (phase !== 3'd0 || count !== 6'd3 || lamps_now() !== 6'b001100) begin
            n_fail++;
            $display("FAIL mid_reset got phase=%0d count=%0d lamps=%b want 0/3/001100", phase, count, lamps_now());
        end
        rst = 1'b0; ped_req = 1'b0; night = 1'b0;
        step();
        n_checks++;
        if (phase !== 3'd0 || count !== 6'd2) begin
            n_fail++; $display("FAIL mid_after got phase=%0d count=%0d want 0/2", phase, count);
        end
        tick = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_cycle();
        test_tick_hold();
        test_night();
        test_ped();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Parametrised two-approach intersection controller, the next generation of the single-approach red/green/yellow sequencer. It drives north-south (NS) and east-west (EW) lamp sets with all-red clearance intervals and exposes a per-phase remaining-time countdown for the display drivers. It also supports a night flashing-yellow mode and an optional pedestrian request that shortens the running green. It sits between the 1 Hz tick prescaler and the lamp/seven-segment output logic.

## Interface
- CW, 6: countdown width in bits; every duration below must be in 1..2^CW-1.
- GREEN_T, 30: green duration in ticks.
- YELLOW_T, 3: yellow duration in ticks.
- RED_CLR_T, 2: all-red clearance duration in ticks.
- PED_T, 5: remaining green after a pedestrian request; must be ≤ GREEN_T.
- clk  in  1  single system clock; all logic rises on posedge clk.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle time-base strobe; all timing advances only on tick=1.
- night  in  1  level; requests flashing-yellow mode.
- ped_req  in  1  pedestrian button, level or pulse; port is always present.
- ns_red / ns_yellow / ns_green  out  1 each  NS lamps, registered.
- ew_red / ew_yellow / ew_green  out  1 each  EW lamps, registered.
- count  out  CW  ticks remaining in the current phase, counting down to 0.
- phase  out  3  current state encoding, for debug and display.

## Operation
- States: NS_GREEN, NS_YELLOW, CLR_1, EW_GREEN, EW_YELLOW, CLR_2, FLASH.
- Normal cycle: NS_GREEN → NS_YELLOW → CLR_1 → EW_GREEN → EW_YELLOW → CLR_2 → NS_GREEN.
- Phase entry loads count = duration-1:
  - GREEN_T for either green state.
  - YELLOW_T for either yellow state.
  - RED_CLR_T for CLR_1 and CLR_2.
- Countdown and transition:
  - A tick with count>0 decrements count.
  - A tick with count==0 moves to the next state.
- Lamps:
  - In every non-FLASH state exactly one lamp per approach is on.
  - The approach that is not green or yellow shows red.
  - CLR_1 and CLR_2 show red on both approaches.
- Night mode:
  - If night=1 at a count==0 tick, the next state is FLASH, whatever phase is ending.
  - In FLASH, red and green are off. ns_yellow and ew_yellow are equal and toggle on every tick, starting at 1 on entry.
  - count holds 0 in FLASH.
  - The first tick with night=0 moves to CLR_2, then the normal cycle resumes at NS_GREEN.
- Reset mid-operation forces the reset state on the next edge, whatever the current state or pending request.
- Simultaneous events: night takes priority over a pending pedestrian truncation at a phase boundary.

## Timing
- Reset values:
  - phase=NS_GREEN, count=GREEN_T-1.
  - ns_green=1, ew_red=1.
  - All other lamps 0.
  - Pedestrian latch cleared.
- Outputs change one clock after the tick that causes them.
- One full normal cycle lasts 2·(GREEN_T+YELLOW_T+RED_CLR_T) ticks.
- With tick=0, all outputs hold indefinitely.

## Configuration
- TLC_PED_EN defined:
  - ped_req=1 on any cycle sets a sticky latch.
  - In a green state with the latch set and count > PED_T-1, count is reloaded to PED_T-1 on the next tick.
  - The latch clears on entry to either yellow.
- TLC_PED_EN undefined: ped_req is ignored, no latch is built, and green always lasts GREEN_T.

## Structure
- Package tlc_pkg holds:
  - The phase state enum (3-bit), shared with the display logic.
  - The phase-to-lamp decode constants.
- Sub-module tlc_phase_timer: a CW-bit loadable down-counter with inputs load, load_val and tick, and a zero flag output. Both the FSM and the pedestrian truncation reuse it.

## Test plan
All scenarios use GREEN_T=4, YELLOW_T=2, RED_CLR_T=1, PED_T=2, with tick=1 every cycle.
- Reset, then 14 ticks: phase goes NS_GREEN (count 3,2,1,0), NS_YELLOW (1,0), CLR_1 (0), then the same pattern for EW, and returns to NS_GREEN with count=3.
- tick=0 for 20 cycles after reset: all outputs unchanged, count=3.
- night=1 during NS_YELLOW: FLASH is entered after that phase. ns_yellow=ew_yellow alternate 1,0,1 and all red/green lamps are 0. Dropping night gives CLR_2 (1 tick), then NS_GREEN with count=3.
- With TLC_PED_EN, pulse ped_req when NS_GREEN count=3: count becomes 1 on the next tick, then the next state is NS_YELLOW. The next EW_GREEN runs the full 4 ticks.
- Without TLC_PED_EN, the same pulse: NS_GREEN still lasts 4 ticks.
- rst=1 during EW_YELLOW: the next edge gives NS_GREEN, count=3, ew_red=1.
